// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
// Module   : sequence_generator
// Purpose  : Serial pattern transmitter. A rising edge on button captures the
//            switch pattern and shifts it out MSB-first on seq_out, qualified
//            by seq_valid, followed by a one-cycle done pulse.
// Options  : SEQ_GEN_LOOP_EN - when defined, frames repeat from the captured
//            pattern until a further start edge requests a stop.
// Revision : 1.0 - initial release
// ============================================================================
module sequence_generator #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [WIDTH-1:0] switch,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    localparam int c_BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_HOLD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(WIDTH - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(BIT_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic                r_btn_q;
    logic [WIDTH-1:0]    r_shreg;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                w_start;
    logic                w_last;
`ifdef SEQ_GEN_LOOP_EN
    logic [WIDTH-1:0]    r_pat_q;
    logic                r_stop_req;
`endif

    assign w_start = button & ~r_btn_q;
    assign w_last  = (r_bit_cnt == '0) && (r_hold_cnt == '0);

    // State register; reset always wins over a coincident start edge.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    // Next-state selection and state-decoded outputs.
    always_comb begin
        w_next    = r_state;
        seq_valid = 1'b0;
        seq_out   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) w_next = c_SEND;
            end
            c_SEND: begin
                seq_valid = 1'b1;
                seq_out   = r_shreg[WIDTH-1];
                busy      = 1'b1;
                if (w_last) w_next = c_DONE;
            end
            c_DONE: begin
                busy = 1'b1;
                done = 1'b1;
`ifdef SEQ_GEN_LOOP_EN
                // A stop request raised in this very cycle also ends the loop.
                w_next = (r_stop_req | w_start) ? c_IDLE : c_SEND;
`else
                w_next = c_IDLE;
`endif
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Datapath: button history, pattern shifter and bit/hold counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q    <= 1'b1;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_btn_q <= button;
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_shreg    <= switch;
                        r_bit_cnt  <= c_BIT_LAST;
                        r_hold_cnt <= c_HOLD_LAST;
                    end
                end
                c_SEND: begin
                    if (r_hold_cnt == '0) begin
                        r_shreg    <= r_shreg << 1;
                        r_hold_cnt <= c_HOLD_LAST;
                        if (r_bit_cnt != '0) r_bit_cnt <= r_bit_cnt - 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                c_DONE: begin
`ifdef SEQ_GEN_LOOP_EN
                    if (w_next == c_SEND) begin
                        r_shreg    <= r_pat_q;
                        r_bit_cnt  <= c_BIT_LAST;
                        r_hold_cnt <= c_HOLD_LAST;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_GEN_LOOP_EN
    // Loop mode: keep a copy of the pattern and latch stop requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat_q    <= '0;
            r_stop_req <= 1'b0;
        end else begin
            if (r_state == c_IDLE && w_start) r_pat_q <= switch;
            if (r_state == c_DONE && w_next == c_IDLE)
                r_stop_req <= 1'b0;
            else if ((r_state == c_SEND || r_state == c_DONE) && w_start)
                r_stop_req <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequence_generator
// Purpose  : Self-checking bench for sequence_generator. Two instances
//            (BIT_CYCLES = 1 and 3) share stimulus; a frame-position model
//            predicts {busy, done, seq_valid, seq_out} every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_generator;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [W-1:0] switch;

    logic out0, val0, busy0, done0;
    logic out1, val1, busy1, done1;
    logic [3:0] obs [2];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model state: active frame, cycle index within frame, pattern, stop flag.
    bit         m_act  [2];
    int         m_t    [2];
    logic [W-1:0] m_pat [2];
    bit         m_stop [2];
    bit         m_prev [2];

    always #5 clk = ~clk;

    sequence_generator #(.WIDTH(W), .BIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .button(button), .switch(switch),
        .seq_out(out0), .seq_valid(val0), .busy(busy0), .done(done0)
    );

    sequence_generator #(.WIDTH(W), .BIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .button(button), .switch(switch),
        .seq_out(out1), .seq_valid(val1), .busy(busy1), .done(done1)
    );

    assign obs[0] = {busy0, done0, val0, out0};
    assign obs[1] = {busy1, done1, val1, out1};

    function automatic int bc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Expected {busy, done, seq_valid, seq_out} for the current cycle.
    function automatic logic [3:0] model_out(input int d);
        int len;
        len = W * bc(d);
        if (!m_act[d])      return 4'b0000;
        else if (m_t[d] < len) return {3'b101, m_pat[d][W-1 - m_t[d] / bc(d)]};
        else                return 4'b1100;
    endfunction

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (busy,done,valid,out) at %0t", tag, got, exp, $time);
    endtask

    // Reference model advance on each rising edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit st;
            if (rst) begin
                m_act[d]  = 1'b0;
                m_t[d]    = 0;
                m_stop[d] = 1'b0;
                m_prev[d] = 1'b1;
            end else begin
                st = button & ~m_prev[d];
                m_prev[d] = button;
                if (!m_act[d]) begin
                    if (st) begin
                        m_act[d] = 1'b1;
                        m_t[d]   = 0;
                        m_pat[d] = switch;
                    end
                end else if (m_t[d] == W * bc(d)) begin
`ifdef SEQ_GEN_LOOP_EN
                    if (m_stop[d] || st) begin
                        m_act[d]  = 1'b0;
                        m_stop[d] = 1'b0;
                    end else begin
                        m_t[d] = 0;
                    end
`else
                    m_act[d] = 1'b0;
`endif
                end else begin
                    m_t[d]++;
                    if (st) m_stop[d] = 1'b1;
                end
            end
        end
    end

    // Compare both instances every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("bc1", obs[0], model_out(0));
            check_eq("bc3", obs[1], model_out(1));
        end
    end

    task automatic press(input logic [W-1:0] pat);
        switch = pat;
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
    endtask

    initial begin
        rst = 1'b1; button = 1'b0; switch = '0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic frame.
        press(8'b00011010);
        repeat (30) @(negedge clk);

        // Switch change mid-frame plus a second press during SEND.
        press(8'b00110111);
        repeat (3) @(negedge clk);
        switch = 8'hFF;
        @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        repeat (60) @(negedge clk);

        // Reset mid-frame with button held high across reset release.
        press(8'hA5);
        repeat (4) @(negedge clk);
        rst = 1'b1; button = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        button = 1'b0;
        @(negedge clk);
        press(8'h81);
        repeat (60) @(negedge clk);

        // Presses at a range of spacings around the end of a frame.
        for (int g = 7; g < 13; g++) begin
            press(8'($urandom));
            repeat (g) @(negedge clk);
        end
        repeat (80) @(negedge clk);

        // Randomised traffic.
        repeat (4000) begin
            button = ($urandom_range(0, 5) == 0);
            switch = 8'($urandom);
            rst    = ($urandom_range(0, 200) == 0);
            @(negedge clk);
        end
        rst = 1'b0; button = 1'b0;
        repeat (40) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
